ddr_cmd_decode: RTL and testbench

Front-end command decoder for the DRAM emulation path. It samples the DDR command pins on every clock and converts them into the single-cycle one-hot command pulses that the per-rank timing FSM consumes: ACT, RD, RDA, WR, WRA, PR, PRA, REF, SRF, PD, PDX, DPD, DPDX, MRR, MRW, BST, CKEH and CKEL. It tracks CKE low-power modes and a per-bank open-row table. Illegal commands are dropped and counted, so the timing FSM only ever sees protocol-legal sequences.

---
 rtl/ddr_cmd_pkg.sv | 50 +++++
 rtl/ddr_bank_table.sv | 53 +++++
 rtl/ddr_cmd_decode.sv | 211 +++++++++++++++++++++
 tb/tb_ddr_cmd_decode.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_cmd_pkg.sv
// Shared widths, low-power mode encoding, command codes and pulse bundle
// for the DDR command decoder.
package ddr_cmd_pkg;

    localparam int unsigned NBANKS = 16;
    localparam int unsigned BW     = $clog2(NBANKS);
    localparam int unsigned AW     = 17;
    localparam int unsigned CW     = 10;
    localparam int unsigned A10    = 10;
    localparam int unsigned ERRW   = 8;

    typedef enum logic [1:0] {
        NORMAL  = 2'd0,
        PWRDN   = 2'd1,
        SELFREF = 2'd2,
        DEEPPD  = 2'd3
    } lp_mode_t;

    // {ras_n, cas_n, we_n} command codes
    localparam logic [2:0] CODE_MRS = 3'b000;
    localparam logic [2:0] CODE_REF = 3'b001;
    localparam logic [2:0] CODE_PRE = 3'b010;
    localparam logic [2:0] CODE_ILL = 3'b011;
    localparam logic [2:0] CODE_WR  = 3'b100;
    localparam logic [2:0] CODE_RD  = 3'b101;
    localparam logic [2:0] CODE_BST = 3'b110;
    localparam logic [2:0] CODE_NOP = 3'b111;

    typedef struct packed {
        logic act;
        logic rd;
        logic rda;
        logic wr;
        logic wra;
        logic pr;
        logic pra;
        logic rf;
        logic srf;
        logic pd;
        logic pdx;
        logic dpd;
        logic dpdx;
        logic mrr;
        logic mrw;
        logic bst;
        logic ckeh;
        logic ckel;
    } cmd_pulse_t;

endpackage

// File: rtl/ddr_bank_table.sv
// Per-bank open bits and stored row addresses. Updates land on the clock
// edge so the following command sees the new table.
module ddr_bank_table
    import ddr_cmd_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_i,
    input  logic              clr_i,
    input  logic              clr_all_i,
    input  logic [BW-1:0]     bank_i,
    input  logic [AW-1:0]     row_i,
    output logic [NBANKS-1:0] open_o,
    output logic              any_open_o,
    output logic [AW-1:0]     row_c_o
);

    logic [NBANKS-1:0] open_q, open_d;
    logic              any_open_q;
    logic [AW-1:0]     row_q [NBANKS];

    always_comb begin
        open_d = open_q;
        if (clr_all_i) begin
            open_d = '0;
        end else if (clr_i) begin
            open_d[bank_i] = 1'b0;
        end else if (set_i) begin
            open_d[bank_i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            open_q     <= '0;
            any_open_q <= 1'b0;
            for (int i = 0; i < int'(NBANKS); i++) begin
                row_q[i] <= '0;
            end
        end else begin
            open_q     <= open_d;
            any_open_q <= |open_d;
            if (set_i) begin
                row_q[bank_i] <= row_i;
            end
        end
    end

    assign open_o     = open_q;
    assign any_open_o = any_open_q;
    assign row_c_o    = row_q[bank_i];

endmodule

// File: rtl/ddr_cmd_decode.sv
// DDR command-pin decoder: one-cycle registered command pulses, CKE low-power
// mode tracking, bank-state legality filtering and a saturating drop counter.
module ddr_cmd_decode
    import ddr_cmd_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cke,
    input  logic              cs_n,
    input  logic              act_n,
    input  logic              ras_n,
    input  logic              cas_n,
    input  logic              we_n,
    input  logic [BW-1:0]     bank,
    input  logic [AW-1:0]     addr,
    output logic              ACT,
    output logic              RD,
    output logic              RDA,
    output logic              WR,
    output logic              WRA,
    output logic              PR,
    output logic              PRA,
    output logic              REF,
    output logic              SRF,
    output logic              PD,
    output logic              PDX,
    output logic              DPD,
    output logic              DPDX,
    output logic              MRR,
    output logic              MRW,
    output logic              BST,
    output logic              CKEH,
    output logic              CKEL,
    output logic [BW-1:0]     cmd_bank,
    output logic [AW-1:0]     cmd_row,
    output logic [CW-1:0]     cmd_col,
    output logic [NBANKS-1:0] open_mask,
    output logic              err,
    output logic [ERRW-1:0]   err_cnt
);

    logic              cke_q;
    lp_mode_t          mode_q, mode_d;
    cmd_pulse_t        pulse_q, pulse_d;
    logic [BW-1:0]     bank_q, bank_d;
    logic [AW-1:0]     row_q, row_d;
    logic [CW-1:0]     col_q, col_d;
    logic              err_q, err_d;
    logic [ERRW-1:0]   err_cnt_q;

    logic              tbl_set, tbl_clr, tbl_clr_all;
    logic              any_open;
    logic [NBANKS-1:0] open_q;
    logic [AW-1:0]     open_row_unused;

    logic [2:0]        code;
    logic              a10;
    logic              bank_open;

    assign code      = {ras_n, cas_n, we_n};
    assign a10       = addr[A10];
    assign bank_open = open_q[bank];

    ddr_bank_table u_bank_table (
        .clk        (clk),
        .rst_n      (rst_n),
        .set_i      (tbl_set),
        .clr_i      (tbl_clr),
        .clr_all_i  (tbl_clr_all),
        .bank_i     (bank),
        .row_i      (addr),
        .open_o     (open_q),
        .any_open_o (any_open),
        .row_c_o    (open_row_unused)
    );

    // Next-pulse decode; CKE edges take priority over pin decode.
    always_comb begin
        pulse_d     = '0;
        mode_d      = mode_q;
        bank_d      = '0;
        row_d       = '0;
        col_d       = '0;
        err_d       = 1'b0;
        tbl_set     = 1'b0;
        tbl_clr     = 1'b0;
        tbl_clr_all = 1'b0;

        if (!cke_q && cke) begin
            pulse_d.ckeh = 1'b1;
            pulse_d.pdx  = (mode_q == PWRDN);
            pulse_d.dpdx = (mode_q == DEEPPD);
            mode_d       = NORMAL;
        end else if (cke_q && !cke && mode_q == NORMAL) begin
            pulse_d.ckel = 1'b1;
            if (!cs_n && code == CODE_REF && !any_open) begin
                pulse_d.srf = 1'b1;
                mode_d      = SELFREF;
            end else if (!cs_n && code == CODE_BST && !any_open) begin
                pulse_d.dpd = 1'b1;
                mode_d      = DEEPPD;
            end else begin
                // A blocked SRF/DPD entry falls back to plain power-down.
                pulse_d.pd = 1'b1;
                mode_d     = PWRDN;
                err_d      = !cs_n && (code == CODE_REF || code == CODE_BST);
            end
        end else if (cke_q && cke && !cs_n && mode_q == NORMAL) begin
            if (!act_n) begin
                if (bank_open) begin
                    err_d = 1'b1;
                end else begin
                    pulse_d.act = 1'b1;
                    tbl_set     = 1'b1;
                    row_d       = addr;
                end
            end else begin
                case (code)
                    CODE_MRS: begin
                        err_d       = any_open;
                        pulse_d.mrr = !any_open && a10;
                        pulse_d.mrw = !any_open && !a10;
                    end
                    CODE_REF: begin
                        err_d      = any_open;
                        pulse_d.rf = !any_open;
                    end
                    CODE_PRE: begin
                        pulse_d.pra = a10;
                        pulse_d.pr  = !a10;
                        tbl_clr_all = a10;
                        tbl_clr     = !a10;
                    end
                    CODE_ILL: err_d = 1'b1;
                    CODE_WR: begin
                        err_d       = !bank_open;
                        pulse_d.wr  = bank_open && !a10;
                        pulse_d.wra = bank_open && a10;
                        tbl_clr     = bank_open && a10;
                        col_d       = bank_open ? addr[CW-1:0] : '0;
                    end
                    CODE_RD: begin
                        err_d       = !bank_open;
                        pulse_d.rd  = bank_open && !a10;
                        pulse_d.rda = bank_open && a10;
                        tbl_clr     = bank_open && a10;
                        col_d       = bank_open ? addr[CW-1:0] : '0;
                    end
                    CODE_BST: begin
                        err_d       = !bank_open;
                        pulse_d.bst = bank_open;
                    end
                    default: ;
                endcase
            end
            if (pulse_d != '0) begin
                bank_d = bank;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cke_q     <= 1'b0;
            mode_q    <= NORMAL;
            pulse_q   <= '0;
            bank_q    <= '0;
            row_q     <= '0;
            col_q     <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            cke_q   <= cke;
            mode_q  <= mode_d;
            pulse_q <= pulse_d;
            bank_q  <= bank_d;
            row_q   <= row_d;
            col_q   <= col_d;
            err_q   <= err_d;
            if (err_d && !(&err_cnt_q)) begin
                err_cnt_q <= err_cnt_q + ERRW'(1);
            end
        end
    end

    assign ACT       = pulse_q.act;
    assign RD        = pulse_q.rd;
    assign RDA       = pulse_q.rda;
    assign WR        = pulse_q.wr;
    assign WRA       = pulse_q.wra;
    assign PR        = pulse_q.pr;
    assign PRA       = pulse_q.pra;
    assign REF       = pulse_q.rf;
    assign SRF       = pulse_q.srf;
    assign PD        = pulse_q.pd;
    assign PDX       = pulse_q.pdx;
    assign DPD       = pulse_q.dpd;
    assign DPDX      = pulse_q.dpdx;
    assign MRR       = pulse_q.mrr;
    assign MRW       = pulse_q.mrw;
    assign BST       = pulse_q.bst;
    assign CKEH      = pulse_q.ckeh;
    assign CKEL      = pulse_q.ckel;
    assign cmd_bank  = bank_q;
    assign cmd_row   = row_q;
    assign cmd_col   = col_q;
    assign open_mask = open_q;
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_ddr_cmd_decode.sv
// Bench for ddr_cmd_decode: directed vector table, counter saturation and
// async reset sequence, then random pins against a behavioural model.
module tb_ddr_cmd_decode;
    import ddr_cmd_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cke = 1'b0, cs_n = 1'b1, act_n = 1'b1;
    logic        ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
    logic [3:0]  bank = '0;
    logic [16:0] addr = '0;

    logic ACT, RD, RDA, WR, WRA, PR, PRA, REF, SRF, PD, PDX, DPD, DPDX;
    logic MRR, MRW, BST, CKEH, CKEL, err;
    logic [3:0]  cmd_bank;
    logic [16:0] cmd_row;
    logic [9:0]  cmd_col;
    logic [15:0] open_mask;
    logic [7:0]  err_cnt;

    always #5 clk = ~clk;

    ddr_cmd_decode dut (
        .clk(clk), .rst_n(rst_n), .cke(cke), .cs_n(cs_n), .act_n(act_n),
        .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n), .bank(bank), .addr(addr),
        .ACT(ACT), .RD(RD), .RDA(RDA), .WR(WR), .WRA(WRA), .PR(PR), .PRA(PRA),
        .REF(REF), .SRF(SRF), .PD(PD), .PDX(PDX), .DPD(DPD), .DPDX(DPDX),
        .MRR(MRR), .MRW(MRW), .BST(BST), .CKEH(CKEH), .CKEL(CKEL),
        .cmd_bank(cmd_bank), .cmd_row(cmd_row), .cmd_col(cmd_col),
        .open_mask(open_mask), .err(err), .err_cnt(err_cnt)
    );

    localparam logic [17:0] B_ACT  = 18'h20000, B_RD   = 18'h10000, B_RDA = 18'h08000;
    localparam logic [17:0] B_WR   = 18'h04000, B_WRA  = 18'h02000, B_PR  = 18'h01000;
    localparam logic [17:0] B_PRA  = 18'h00800, B_REF  = 18'h00400, B_SRF = 18'h00200;
    localparam logic [17:0] B_PD   = 18'h00100, B_PDX  = 18'h00080, B_DPD = 18'h00040;
    localparam logic [17:0] B_DPDX = 18'h00020, B_MRR  = 18'h00010, B_MRW = 18'h00008;
    localparam logic [17:0] B_BST  = 18'h00004, B_CKEH = 18'h00002, B_CKEL = 18'h00001;

    logic [17:0] pulses;
    assign pulses = {ACT, RD, RDA, WR, WRA, PR, PRA, REF, SRF, PD, PDX, DPD, DPDX,
                     MRR, MRW, BST, CKEH, CKEL};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] agg(input logic [3:0] b, input logic [16:0] r,
                                        input logic [9:0] c, input logic [15:0] o,
                                        input logic e, input logic [7:0] n);
        return {8'h00, b, r, c, o, e, n};
    endfunction

    task automatic drive(input logic k, input logic c, input logic a, input logic [2:0] cd,
                         input logic [3:0] b, input logic [16:0] ad);
        @(negedge clk);
        cke = k; cs_n = c; act_n = a; {ras_n, cas_n, we_n} = cd; bank = b; addr = ad;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        cke = 1'b0; cs_n = 1'b1; act_n = 1'b1; {ras_n, cas_n, we_n} = 3'b111;
        bank = '0; addr = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        k, c, a;
        logic [2:0]  cd;
        logic [3:0]  b;
        logic [16:0] ad;
        logic [17:0] p;
        logic [3:0]  eb;
        logic [16:0] er;
        logic [9:0]  ec;
        logic [15:0] eo;
        logic        ee;
        logic [7:0]  en;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t v(input logic k, input logic c, input logic a, input logic [2:0] cd,
                               input logic [3:0] b, input logic [16:0] ad, input logic [17:0] p,
                               input logic [3:0] eb, input logic [16:0] er, input logic [9:0] ec,
                               input logic [15:0] eo, input logic ee, input logic [7:0] en);
        vec_t t;
        t.k = k; t.c = c; t.a = a; t.cd = cd; t.b = b; t.ad = ad; t.p = p;
        t.eb = eb; t.er = er; t.ec = ec; t.eo = eo; t.ee = ee; t.en = en;
        return t;
    endfunction

    // Behavioural model state for the random phase
    int          m_mode;
    bit          m_cke_prev;
    bit          m_open[16];
    int          m_cnt;

    function automatic bit m_any_open();
        foreach (m_open[i]) if (m_open[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [15:0] m_open_vec();
        logic [15:0] r = '0;
        foreach (m_open[i]) r[i] = m_open[i];
        return r;
    endfunction

    initial begin
        do_reset();
        #1;
        check("reset_pulses", 64'(pulses), 64'd0);
        check("reset_state", agg(cmd_bank, cmd_row, cmd_col, open_mask, err, err_cnt), 64'd0);

        tv.push_back(v(1,0,0,3'b000,3,17'h1ABC, B_CKEH,        0,0,0,     16'h0000,0,0));
        tv.push_back(v(1,0,0,3'b000,3,17'h1ABC, B_ACT,         3,17'h1ABC,0,16'h0008,0,0));
        tv.push_back(v(1,0,1,3'b101,3,17'h0040, B_RD,          3,0,10'h040,16'h0008,0,0));
        tv.push_back(v(1,0,0,3'b000,3,17'h1ABC, 0,             0,0,0,     16'h0008,1,1));
        tv.push_back(v(1,0,0,3'b000,1,17'h0011, B_ACT,         1,17'h0011,0,16'h000A,0,1));
        tv.push_back(v(1,0,0,3'b000,2,17'h0022, B_ACT,         2,17'h0022,0,16'h000E,0,1));
        tv.push_back(v(1,0,1,3'b010,0,17'h0400, B_PRA,         0,0,0,     16'h0000,0,1));
        tv.push_back(v(1,0,1,3'b001,0,17'h0000, B_REF,         0,0,0,     16'h0000,0,1));
        tv.push_back(v(1,0,1,3'b111,0,17'h0000, 0,             0,0,0,     16'h0000,0,1));
        tv.push_back(v(0,0,1,3'b111,0,17'h0000, B_CKEL|B_PD,   0,0,0,     16'h0000,0,1));
        tv.push_back(v(0,0,0,3'b000,4,17'h1234, 0,             0,0,0,     16'h0000,0,1));
        tv.push_back(v(1,0,0,3'b000,4,17'h1234, B_CKEH|B_PDX,  0,0,0,     16'h0000,0,1));
        tv.push_back(v(1,1,1,3'b111,0,17'h0000, 0,             0,0,0,     16'h0000,0,1));
        tv.push_back(v(0,0,1,3'b001,0,17'h0000, B_CKEL|B_SRF,  0,0,0,     16'h0000,0,1));
        tv.push_back(v(1,0,1,3'b111,0,17'h0000, B_CKEH,        0,0,0,     16'h0000,0,1));
        tv.push_back(v(1,0,1,3'b111,0,17'h0000, 0,             0,0,0,     16'h0000,0,1));
        tv.push_back(v(1,0,0,3'b000,0,17'h0005, B_ACT,         0,17'h0005,0,16'h0001,0,1));
        tv.push_back(v(0,0,1,3'b110,0,17'h0000, B_CKEL|B_PD,   0,0,0,     16'h0001,1,2));
        tv.push_back(v(1,0,1,3'b111,0,17'h0000, B_CKEH|B_PDX,  0,0,0,     16'h0001,0,2));
        tv.push_back(v(1,0,1,3'b010,0,17'h0400, B_PRA,         0,0,0,     16'h0000,0,2));
        tv.push_back(v(0,0,1,3'b110,0,17'h0000, B_CKEL|B_DPD,  0,0,0,     16'h0000,0,2));
        tv.push_back(v(1,0,1,3'b111,0,17'h0000, B_CKEH|B_DPDX, 0,0,0,     16'h0000,0,2));
        tv.push_back(v(1,0,1,3'b111,0,17'h0000, 0,             0,0,0,     16'h0000,0,2));
        tv.push_back(v(1,0,1,3'b100,5,17'h0000, 0,             0,0,0,     16'h0000,1,3));
        tv.push_back(v(1,0,0,3'b000,5,17'h1FFFF,B_ACT,         5,17'h1FFFF,0,16'h0020,0,3));
        tv.push_back(v(1,0,1,3'b100,5,17'h047F, B_WRA,         5,0,10'h07F,16'h0000,0,3));
        tv.push_back(v(1,0,1,3'b101,5,17'h0010, 0,             0,0,0,     16'h0000,1,4));
        tv.push_back(v(1,0,1,3'b000,0,17'h0000, B_MRW,         0,0,0,     16'h0000,0,4));
        tv.push_back(v(1,0,1,3'b011,0,17'h0000, 0,             0,0,0,     16'h0000,1,5));
        tv.push_back(v(1,0,1,3'b110,0,17'h0000, 0,             0,0,0,     16'h0000,1,6));
        tv.push_back(v(1,0,1,3'b000,0,17'h0400, B_MRR,         0,0,0,     16'h0000,0,6));
        tv.push_back(v(1,0,0,3'b000,7,17'h0077, B_ACT,         7,17'h0077,0,16'h0080,0,6));
        tv.push_back(v(1,0,1,3'b010,7,17'h0000, B_PR,          7,0,0,     16'h0000,0,6));
        tv.push_back(v(1,0,1,3'b010,7,17'h0000, B_PR,          7,0,0,     16'h0000,0,6));
        tv.push_back(v(1,0,0,3'b000,9,17'h0099, B_ACT,         9,17'h0099,0,16'h0200,0,6));

        foreach (tv[i]) begin
            drive(tv[i].k, tv[i].c, tv[i].a, tv[i].cd, tv[i].b, tv[i].ad);
            check($sformatf("vec%0d_pulses", i), 64'(pulses), 64'(tv[i].p));
            check($sformatf("vec%0d_state", i),
                  agg(cmd_bank, cmd_row, cmd_col, open_mask, err, err_cnt),
                  agg(tv[i].eb, tv[i].er, tv[i].ec, tv[i].eo, tv[i].ee, tv[i].en));
        end

        // Illegal-code burst drives the counter into saturation.
        for (int i = 0; i < 256; i++) begin
            drive(1, 0, 1, 3'b011, 0, 17'h0000);
            check($sformatf("burst%0d_err", i), 64'({pulses, err}), 64'd1);
        end
        check("err_cnt_sat", 64'(err_cnt), 64'd255);
        drive(1, 0, 1, 3'b011, 0, 17'h0000);
        check("err_cnt_hold", 64'({err, err_cnt}), 64'h1FF);
        check("open_before_rst", 64'(open_mask), 64'h0200);

        // Asynchronous reset mid-burst clears everything without a clock edge.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_pulses", 64'(pulses), 64'd0);
        check("async_rst_state", agg(cmd_bank, cmd_row, cmd_col, open_mask, err, err_cnt), 64'd0);
        @(negedge clk);
        cke = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 0, 0, 3'b000, 3, 17'h1ABC);
        check("post_rst_ckeh", 64'(pulses), 64'(B_CKEH));
        check("post_rst_state", agg(cmd_bank, cmd_row, cmd_col, open_mask, err, err_cnt), 64'd0);

        // Random phase
        do_reset();
        m_mode = 0; m_cke_prev = 1'b0; m_cnt = 0;
        foreach (m_open[i]) m_open[i] = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic        k, c, a, a10, bad, bank_cmd;
            logic [2:0]  cd;
            logic [3:0]  b;
            logic [16:0] ad;
            logic [17:0] ep;
            logic        ee;
            logic [16:0] er;
            logic [9:0]  ec;
            int          want;

            k  = m_cke_prev ? ($urandom_range(0, 99) >= 4) : ($urandom_range(0, 99) >= 60);
            c  = ($urandom_range(0, 99) < 15);
            a  = ($urandom_range(0, 99) >= 20);
            cd = 3'($urandom_range(0, 7));
            b  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
            ad = 17'($urandom);
            a10 = ad[10];

            ep = '0; ee = 1'b0; bad = 1'b0; bank_cmd = 1'b0;
            if (!m_cke_prev && k) begin
                ep = B_CKEH | ((m_mode == 1) ? B_PDX : 18'h0) | ((m_mode == 3) ? B_DPDX : 18'h0);
                m_mode = 0;
            end else if (m_cke_prev && !k) begin
                want = 1;
                if (!c && cd == 3'b001) want = 2;
                if (!c && cd == 3'b110) want = 3;
                if (want != 1 && m_any_open()) begin
                    ee = 1'b1;
                    want = 1;
                end
                ep = B_CKEL | ((want == 1) ? B_PD : (want == 2) ? B_SRF : B_DPD);
                m_mode = want;
            end else if (m_cke_prev && k && !c) begin
                if (!a) begin
                    ep = B_ACT; bad = m_open[b]; bank_cmd = 1'b1;
                end else begin
                    case (cd)
                        3'd0: begin ep = a10 ? B_MRR : B_MRW; bad = m_any_open(); end
                        3'd1: begin ep = B_REF; bad = m_any_open(); end
                        3'd2: begin ep = a10 ? B_PRA : B_PR; bank_cmd = !a10; end
                        3'd3: bad = 1'b1;
                        3'd4: begin ep = a10 ? B_WRA : B_WR; bad = !m_open[b]; bank_cmd = 1'b1; end
                        3'd5: begin ep = a10 ? B_RDA : B_RD; bad = !m_open[b]; bank_cmd = 1'b1; end
                        3'd6: begin ep = B_BST; bad = !m_open[b]; bank_cmd = 1'b1; end
                        default: ;
                    endcase
                end
                if (bad) begin
                    ee = 1'b1; ep = '0; bank_cmd = 1'b0;
                end
            end

            er = (ep == B_ACT) ? ad : 17'h0;
            ec = (ep == B_RD || ep == B_RDA || ep == B_WR || ep == B_WRA) ? ad[9:0] : 10'h0;
            if (ep == B_ACT) m_open[b] = 1'b1;
            if (ep == B_PR || ep == B_RDA || ep == B_WRA) m_open[b] = 1'b0;
            if (ep == B_PRA) foreach (m_open[j]) m_open[j] = 1'b0;
            if (ee && m_cnt < 255) m_cnt++;
            m_cke_prev = k;

            drive(k, c, a, cd, b, ad);
            check($sformatf("rnd%0d_pulses", cyc), 64'(pulses), 64'(ep));
            check($sformatf("rnd%0d_state", cyc),
                  agg(4'h0, cmd_row, cmd_col, open_mask, err, err_cnt),
                  agg(4'h0, er, ec, m_open_vec(), ee, 8'(m_cnt)));
            if (ep == '0)
                check($sformatf("rnd%0d_bank_idle", cyc), 64'(cmd_bank), 64'd0);
            else if (bank_cmd)
                check($sformatf("rnd%0d_bank", cyc), 64'(cmd_bank), 64'(b));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
